// File: rtl/tdm_demux_pkg.sv
// ----------------------------------------------------------------------------
// tdm_demux_pkg
//
// Purpose:
//   Shared definitions for the TDM receive path: frame-tracker state
//   encodings and the default channel count / sample width. The matching
//   TDM mux uses the same defaults, so that both ends of a link agree on
//   the frame shape without per-instance overrides.
//
// Contents:
//   tdm_state_t      - frame tracker state (HUNT / LOCKED)
//   TDM_N_CH         - default number of channels per frame
//   TDM_WIDTH        - default bits per sample
//   tdm_cnt_width()  - channel counter width for a given channel count
// ----------------------------------------------------------------------------
package tdm_demux_pkg;

    // HUNT: waiting for a sync-qualified beat to find channel 0.
    // LOCKED: frame position is known and beats are steered by position.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_t;

    localparam int TDM_N_CH  = 4;
    localparam int TDM_WIDTH = 8;

    // The counter must hold 0..n-1. The floor of one bit keeps the
    // declaration legal even for degenerate channel counts.
    function automatic int tdm_cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tdm_demux_frame_tracker.sv
// ----------------------------------------------------------------------------
// tdm_frame_tracker
//
// Purpose:
//   Follows the frame position of an incoming TDM sample stream. It decides
//   which channel slot the current beat belongs to (if any), flags framing
//   violations, and recovers alignment from the in_sync marker.
//
//   The write request (wr_valid / wr_idx) is combinational so that the
//   parent can capture the sample on the same edge that accepts the beat.
//   frame_done, sync_err and locked are registered and therefore appear
//   alongside the captured data and strobe.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   a beat is present this cycle
//   in_sync    in   the current beat is channel 0 of a frame
//   wr_idx     out  channel slot for the current beat (valid with wr_valid)
//   wr_valid   out  the current beat must be written to slot wr_idx
//   frame_done out  one-cycle pulse after the last channel was written
//   sync_err   out  one-cycle pulse after any framing violation
//   locked     out  high while the tracker is in the LOCKED state
// ----------------------------------------------------------------------------
module tdm_frame_tracker
    import tdm_demux_pkg::*;
#(
    parameter int N_CH = TDM_N_CH,
    parameter int CW   = tdm_cnt_width(N_CH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_sync,
    output logic [CW-1:0] wr_idx,
    output logic          wr_valid,
    output logic          frame_done,
    output logic          sync_err,
    output logic          locked
);

    localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);
    localparam logic [CW-1:0] FIRST_DATA_CH = CW'(1);

    tdm_state_t    state;
    logic [CW-1:0] ch_cnt;

    logic beat_sync;
    logic beat_data;

    // A sync beat always lands in channel 0, whether it starts the first
    // frame, a normal frame, or realigns a truncated one. A plain beat is
    // only stored when we are locked and mid-frame; a plain beat where a
    // sync was expected is a violation and is dropped.
    always_comb begin
        beat_sync = in_valid && in_sync;
        beat_data = in_valid && !in_sync && (state == LOCKED) && (ch_cnt != '0);
        wr_valid  = beat_sync || beat_data;
        wr_idx    = beat_sync ? '0 : ch_cnt;
    end

    // Frame FSM with the channel counter and registered status outputs.
    // Pulses default low each cycle; idle cycles (in_valid=0) leave the
    // state and counter untouched. The counter wraps explicitly at the last
    // channel, so channel counts that are not a power of two work as-is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            ch_cnt     <= '0;
            locked     <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            if (in_valid) begin
                case (state)
                    HUNT: begin
                        if (in_sync) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                            ch_cnt <= FIRST_DATA_CH;
                        end
                    end
                    LOCKED: begin
                        if (in_sync) begin
                            // A sync anywhere but the frame boundary means
                            // the previous frame was cut short: no
                            // frame_done for it, just realign on this beat.
                            if (ch_cnt != '0) begin
                                sync_err <= 1'b1;
                            end
                            ch_cnt <= FIRST_DATA_CH;
                        end else if (ch_cnt == '0) begin
                            // Sync was due but never came: alignment is
                            // lost, so go back to hunting.
                            sync_err <= 1'b1;
                            state    <= HUNT;
                            locked   <= 1'b0;
                            ch_cnt   <= '0;
                        end else if (ch_cnt == LAST_CH) begin
                            frame_done <= 1'b1;
                            ch_cnt     <= '0;
                        end else begin
                            ch_cnt <= ch_cnt + CW'(1);
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                        ch_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// ----------------------------------------------------------------------------
// tdm_demux
//
// Purpose:
//   Receive-side TDM demultiplexer. Takes a serial stream of WIDTH-bit
//   samples, channel 0 of each frame marked by in_sync, and steers every
//   sample into its own per-channel holding register with a one-cycle
//   strobe. Frame alignment and error recovery live in tdm_frame_tracker;
//   this level owns the channel registers and the strobe decode.
//
//   Timing: a beat accepted on edge n is visible on out_data / out_strobe
//   (and frame_done / sync_err / locked) right after edge n. Beats may
//   arrive every cycle; there is no backpressure.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   sample present on in_data this cycle
//   in_sync    in   current valid sample is channel 0
//   in_data    in   WIDTH-bit sample
//   out_data   out  channel k held in bits [k*WIDTH +: WIDTH]
//   out_strobe out  bit k pulses for one cycle when channel k was updated
//   frame_done out  one-cycle pulse when the last channel was written
//   locked     out  high while frame alignment is established
//   sync_err   out  one-cycle pulse on any framing violation
// ----------------------------------------------------------------------------
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int N_CH  = TDM_N_CH,
    parameter int WIDTH = TDM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_sync,
    input  logic [WIDTH-1:0]      in_data,
    output logic [N_CH*WIDTH-1:0] out_data,
    output logic [N_CH-1:0]       out_strobe,
    output logic                  frame_done,
    output logic                  locked,
    output logic                  sync_err
);

    localparam int CW = tdm_cnt_width(N_CH);

    logic [CW-1:0] wr_idx;
    logic          wr_valid;

    tdm_frame_tracker #(
        .N_CH (N_CH),
        .CW   (CW)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sync    (in_sync),
        .wr_idx     (wr_idx),
        .wr_valid   (wr_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .locked     (locked)
    );

    // Channel holding registers and strobe decode. Only the addressed slot
    // is loaded; every other slot keeps its last value until its own turn
    // comes round. The strobe is rebuilt every cycle so it is a single-cycle
    // pulse even under back-to-back beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data   <= '0;
            out_strobe <= '0;
        end else begin
            out_strobe <= '0;
            for (int k = 0; k < N_CH; k++) begin
                if (wr_valid && (wr_idx == CW'(k))) begin
                    out_data[k*WIDTH +: WIDTH] <= in_data;
                    out_strobe[k]              <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// ----------------------------------------------------------------------------
// tb_tdm_demux
//
// Self-checking bench for tdm_demux. A behavioural model tracks the frame
// position as a plain integer (-1 while hunting for sync) and the channel
// contents as an array; every cycle the DUT outputs are compared against it.
// Directed scenarios come first, followed by a randomized stream.
// ----------------------------------------------------------------------------
module tb_tdm_demux;

    localparam int N_CH  = 4;
    localparam int WIDTH = 8;

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic                  in_sync;
    logic [WIDTH-1:0]      in_data;
    logic [N_CH*WIDTH-1:0] out_data;
    logic [N_CH-1:0]       out_strobe;
    logic                  frame_done;
    logic                  locked;
    logic                  sync_err;

    tdm_demux #(
        .N_CH  (N_CH),
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sync    (in_sync),
        .in_data    (in_data),
        .out_data   (out_data),
        .out_strobe (out_strobe),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: pos is the channel the next plain beat belongs to, or -1 when
    // no frame alignment is known.
    int               pos;
    logic [WIDTH-1:0] mdl_ch [N_CH];
    logic [N_CH-1:0]  exp_strobe;
    logic             exp_done;
    logic             exp_err;

    function automatic logic [N_CH*WIDTH-1:0] packModel();
        logic [N_CH*WIDTH-1:0] v;
        v = '0;
        for (int k = 0; k < N_CH; k++) v[k*WIDTH +: WIDTH] = mdl_ch[k];
        return v;
    endfunction

    task automatic modelReset();
        pos        = -1;
        exp_strobe = '0;
        exp_done   = 1'b0;
        exp_err    = 1'b0;
        for (int k = 0; k < N_CH; k++) mdl_ch[k] = '0;
    endtask

    task automatic modelBeat(input logic v, input logic s, input logic [WIDTH-1:0] d);
        exp_strobe = '0;
        exp_done   = 1'b0;
        exp_err    = 1'b0;
        if (v) begin
            if (s) begin
                if (pos > 0) exp_err = 1'b1;
                mdl_ch[0]     = d;
                exp_strobe[0] = 1'b1;
                pos           = 1;
            end else if (pos == 0) begin
                exp_err = 1'b1;
                pos     = -1;
            end else if (pos > 0) begin
                mdl_ch[pos]     = d;
                exp_strobe[pos] = 1'b1;
                if (pos == N_CH - 1) begin
                    exp_done = 1'b1;
                    pos      = 0;
                end else begin
                    pos = pos + 1;
                end
            end
        end
    endtask

    task automatic checkValue(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h at t=%0t",
                   tag, observed, expected, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".data"},   64'(out_data),   64'(packModel()));
        checkValue({tag, ".strobe"}, 64'(out_strobe), 64'(exp_strobe));
        checkValue({tag, ".done"},   64'(frame_done), 64'(exp_done));
        checkValue({tag, ".err"},    64'(sync_err),   64'(exp_err));
        checkValue({tag, ".locked"}, 64'(locked),     64'(pos >= 0));
    endtask

    // Drive one cycle (off the clock edge), let the edge take it, update the
    // model and compare shortly after the edge.
    task automatic applyStimulus(input string tag, input logic v, input logic s,
                                 input logic [WIDTH-1:0] d);
        in_valid = v;
        in_sync  = s;
        in_data  = d;
        @(posedge clk);
        modelBeat(v, s, d);
        #1;
        checkOutput(tag);
    endtask

    task automatic idleCycles(input string tag, input int n);
        for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 1'b0, 8'($urandom));
    endtask

    logic [7:0] frame1 [4];
    logic       rs;
    logic       rv;

    initial begin
        frame1[0] = 8'h11; frame1[1] = 8'h22; frame1[2] = 8'h33; frame1[3] = 8'h44;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        in_data  = '0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset");
        rst = 1'b0;

        // One clean frame.
        for (int i = 0; i < 4; i++) applyStimulus("frame1", 1'b1, (i == 0), frame1[i]);
        checkValue("frame1_word", 64'(out_data), 64'h44332211);

        // Missing sync: next frame boundary without in_sync.
        applyStimulus("missing", 1'b1, 1'b0, 8'h77);
        checkValue("missing_word", 64'(out_data), 64'h44332211);
        checkValue("missing_unlock", 64'(locked), 64'd0);

        // HUNT discard, then a frame relocks.
        for (int i = 0; i < 3; i++) applyStimulus("hunt", 1'b1, 1'b0, 8'(8'hAA + i));
        for (int i = 0; i < 4; i++) applyStimulus("hunt_frame", 1'b1, (i == 0), 8'(i + 1));
        checkValue("hunt_word", 64'(out_data), 64'h04030201);

        // Gapped input.
        for (int i = 0; i < 4; i++) begin
            applyStimulus("gap", 1'b1, (i == 0), frame1[i]);
            idleCycles("gap_idle", 2);
        end
        checkValue("gap_word", 64'(out_data), 64'h44332211);

        // Early sync realigns.
        applyStimulus("early", 1'b1, 1'b1, 8'h10);
        applyStimulus("early", 1'b1, 1'b0, 8'h20);
        applyStimulus("early_sync", 1'b1, 1'b1, 8'h30);
        checkValue("early_err", 64'(sync_err), 64'd1);
        for (int i = 0; i < 3; i++) applyStimulus("early", 1'b1, 1'b0, 8'(8'h40 + 8'h10 * i));
        checkValue("early_word", 64'(out_data), 64'h60504030);
        checkValue("early_locked", 64'(locked), 64'd1);

        // Asynchronous reset mid-frame.
        applyStimulus("rst_mid", 1'b1, 1'b1, 8'hC1);
        applyStimulus("rst_mid", 1'b1, 1'b0, 8'hC2);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkOutput("async_rst");
        #3 rst = 1'b0;
        applyStimulus("post_rst", 1'b1, 1'b0, 8'hC3);
        checkValue("post_rst_strobe", 64'(out_strobe), 64'd0);
        for (int i = 0; i < 4; i++) applyStimulus("post_rst_frame", 1'b1, (i == 0), 8'(8'hD0 + i));

        // Randomized stream: mostly well-formed frames with occasional
        // missing/early syncs and idle gaps.
        for (int n = 0; n < 400; n++) begin
            rv = ($urandom_range(0, 3) != 0);
            if (pos <= 0) rs = ($urandom_range(0, 7) != 0);
            else          rs = ($urandom_range(0, 9) == 0);
            applyStimulus("random", rv, rs, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
